// File: rtl/input_player_pkg.sv
// ---------------------------------------------------------------------------
// input_player_pkg
// Shared definitions for the host-to-reservoir stimulus player:
//   state_t     - controller state encoding (IDLE, LOAD, READY, PLAY)
//   nbytes()    - number of bit-packed bytes needed for a time series
//   addr_width()- byte-RAM address width for a given depth (minimum 1)
// ---------------------------------------------------------------------------
package input_player_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        PLAY  = 2'd3
    } state_t;

    // Eight samples per byte, rounded up.
    function automatic int nbytes(input int nr_samples);
        return (nr_samples + 7) / 8;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/input_player_mem.sv
// ---------------------------------------------------------------------------
// input_player_mem
// Byte RAM holding the bit-packed time series.
//   CLOCK_50  in   clock, rising edge
//   wr_en     in   write strobe
//   wr_addr   in   write byte address
//   wr_data   in   byte to store
//   rd_addr   in   read byte address
//   rd_data   out  registered read data (one cycle after rd_addr)
// ---------------------------------------------------------------------------
module input_player_mem #(
    parameter int DEPTH = 25,
    parameter int AW    = 5
) (
    input  logic          CLOCK_50,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [0:DEPTH-1];
    logic [7:0] rd_data_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; stale
    // contents are harmless because the controller clears 'loaded' and
    // never plays until a full series has been rewritten.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/input_player.sv
// ---------------------------------------------------------------------------
// input_player
// Receives a bit-packed input time series from the host byte stream, stores
// it, and replays it one bit per clock into the reservoir.
//
// Ports:
//   CLOCK_50     in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   received     in   one-cycle strobe, receive_byte valid
//   receive_byte in   host byte, LSB = earliest sample
//   load_signal  in   level: start / restart loading
//   play_signal  in   level: start playback
//   input_bit    out  stimulus bit to reservoir
//   input_valid  out  input_bit carries a sample
//   loaded       out  complete series stored and replayable
//   busy         out  high while loading or playing
//   bytes_loaded out  bytes written in the current load
//
// Build option:
//   INPUT_PLAYER_LOOP_EN - playback wraps continuously; play_signal or
//   load_signal during PLAY requests a stop at the end of the current pass.
// ---------------------------------------------------------------------------
module input_player
    import input_player_pkg::*;
#(
    parameter int nr_samples   = 200,
    parameter int log_nr_lines = 10
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    received,
    input  logic [7:0]              receive_byte,
    input  logic                    load_signal,
    input  logic                    play_signal,
    output logic                    input_bit,
    output logic                    input_valid,
    output logic                    loaded,
    output logic                    busy,
    output logic [log_nr_lines-1:0] bytes_loaded
);

    localparam int NBYTES = nbytes(nr_samples);
    localparam int MEM_AW = addr_width(NBYTES);

    localparam logic [log_nr_lines-1:0] ONE       = log_nr_lines'(1);
    localparam logic [log_nr_lines-1:0] LAST_BYTE = log_nr_lines'(NBYTES - 1);
    localparam logic [log_nr_lines-1:0] LAST_IDX  = log_nr_lines'(nr_samples - 1);

    state_t                  state_q, state_d;
    logic [log_nr_lines-1:0] bytes_loaded_q, bytes_loaded_d;
    logic [log_nr_lines-1:0] idx_q, idx_d;
    logic                    loaded_q, loaded_d;
    logic                    busy_q, busy_d;
`ifdef INPUT_PLAYER_LOOP_EN
    logic                    stop_q, stop_d;
    logic                    load_req_q, load_req_d;
`endif

    // Playback pipeline: stage 1 aligns with the RAM read, stage 2 is the
    // output register.
    logic                    play_v1_q, play_v1_d;
    logic [2:0]              bit_sel_q, bit_sel_d;
    logic                    input_bit_q, input_bit_d;
    logic                    input_valid_q, input_valid_d;

    logic                    wr_en;
    logic [7:0]              rd_data;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        bytes_loaded_d = bytes_loaded_q;
        idx_d          = idx_q;
        loaded_d       = loaded_q;
        wr_en          = 1'b0;
`ifdef INPUT_PLAYER_LOOP_EN
        stop_d         = stop_q;
        load_req_d     = load_req_q;
`endif

        case (state_q)
            IDLE: begin
                if (load_signal) begin
                    state_d        = LOAD;
                    bytes_loaded_d = '0;
                    loaded_d       = 1'b0;
                end
            end

            LOAD: begin
                // A restart wins over a byte arriving on the same edge.
                if (load_signal) begin
                    bytes_loaded_d = '0;
                end else if (received) begin
                    wr_en          = 1'b1;
                    bytes_loaded_d = bytes_loaded_q + ONE;
                    if (bytes_loaded_q == LAST_BYTE) begin
                        state_d  = READY;
                        loaded_d = 1'b1;
                    end
                end
            end

            READY: begin
                if (load_signal) begin
                    state_d        = LOAD;
                    bytes_loaded_d = '0;
                    loaded_d       = 1'b0;
                end else if (play_signal) begin
                    state_d = PLAY;
                    idx_d   = '0;
                end
            end

            PLAY: begin
`ifdef INPUT_PLAYER_LOOP_EN
                if (play_signal) stop_d     = 1'b1;
                if (load_signal) load_req_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    // Requests seen on the final edge of a pass still count.
                    if (load_req_d) begin
                        state_d        = LOAD;
                        bytes_loaded_d = '0;
                        loaded_d       = 1'b0;
                        stop_d         = 1'b0;
                        load_req_d     = 1'b0;
                    end else if (stop_d) begin
                        state_d = READY;
                        stop_d  = 1'b0;
                    end
                end else begin
                    idx_d = idx_q + ONE;
                end
`else
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ONE;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        // busy follows the state being entered so it rises on the same edge.
        busy_d = (state_d == LOAD) || (state_d == PLAY);

        play_v1_d     = (state_q == PLAY);
        bit_sel_d     = idx_q[2:0];
        input_valid_d = play_v1_q;
        input_bit_d   = play_v1_q & rd_data[bit_sel_q];
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= IDLE;
            bytes_loaded_q <= '0;
            idx_q          <= '0;
            loaded_q       <= 1'b0;
            busy_q         <= 1'b0;
`ifdef INPUT_PLAYER_LOOP_EN
            stop_q         <= 1'b0;
            load_req_q     <= 1'b0;
`endif
            play_v1_q      <= 1'b0;
            bit_sel_q      <= '0;
            input_bit_q    <= 1'b0;
            input_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bytes_loaded_q <= bytes_loaded_d;
            idx_q          <= idx_d;
            loaded_q       <= loaded_d;
            busy_q         <= busy_d;
`ifdef INPUT_PLAYER_LOOP_EN
            stop_q         <= stop_d;
            load_req_q     <= load_req_d;
`endif
            play_v1_q      <= play_v1_d;
            bit_sel_q      <= bit_sel_d;
            input_bit_q    <= input_bit_d;
            input_valid_q  <= input_valid_d;
        end
    end

    input_player_mem #(
        .DEPTH (NBYTES),
        .AW    (MEM_AW)
    ) u_mem (
        .CLOCK_50 (CLOCK_50),
        .wr_en    (wr_en & ~reset),
        .wr_addr  (bytes_loaded_q[MEM_AW-1:0]),
        .wr_data  (receive_byte),
        .rd_addr  (idx_q[MEM_AW+2:3]),
        .rd_data  (rd_data)
    );

    assign input_bit    = input_bit_q;
    assign input_valid  = input_valid_q;
    assign loaded       = loaded_q;
    assign busy         = busy_q;
    assign bytes_loaded = bytes_loaded_q;

endmodule

// File: tb/tb_input_player.sv
// ---------------------------------------------------------------------------
// tb_input_player
// Directed bench for input_player: a 200-sample instance (dut) and a
// 13-sample instance (dut13). Inputs change 1 time unit after the rising
// edge; outputs are sampled at the same point. Define INPUT_PLAYER_LOOP_EN
// for both bench and RTL to exercise continuous playback.
// ---------------------------------------------------------------------------
module tb_input_player;

    logic       CLOCK_50 = 1'b0;
    logic       reset;

    // 200-sample instance
    logic       received, load_signal, play_signal;
    logic [7:0] receive_byte;
    logic       input_bit, input_valid, loaded, busy;
    logic [9:0] bytes_loaded;

    // 13-sample instance
    logic       s_received, s_load, s_play;
    logic [7:0] s_byte;
    logic       s_bit, s_valid, s_loaded, s_busy;
    logic [9:0] s_bytes_loaded;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model [0:24];
    logic [199:0] seq1, seq2;

    always #5 CLOCK_50 = ~CLOCK_50;

    input_player #(.nr_samples(200), .log_nr_lines(10)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .received     (received),
        .receive_byte (receive_byte),
        .load_signal  (load_signal),
        .play_signal  (play_signal),
        .input_bit    (input_bit),
        .input_valid  (input_valid),
        .loaded       (loaded),
        .busy         (busy),
        .bytes_loaded (bytes_loaded)
    );

    input_player #(.nr_samples(13), .log_nr_lines(10)) dut13 (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .received     (s_received),
        .receive_byte (s_byte),
        .load_signal  (s_load),
        .play_signal  (s_play),
        .input_bit    (s_bit),
        .input_valid  (s_valid),
        .loaded       (s_loaded),
        .busy         (s_busy),
        .bytes_loaded (s_bytes_loaded)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input int i);
        logic [7:0] b;
        b = model[i / 8];
        return b[i % 8];
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_bit"},   {31'd0, input_bit},   32'd0);
        check({tag, "_valid"}, {31'd0, input_valid}, 32'd0);
        check({tag, "_loaded"},{31'd0, loaded},      32'd0);
        check({tag, "_busy"},  {31'd0, busy},        32'd0);
        check({tag, "_bytes"}, {22'd0, bytes_loaded},32'd0);
    endtask

    // Pulse load_signal, then stream n bytes back-to-back starting at base.
    task automatic load_bytes(input int n, input logic [7:0] base);
        load_signal = 1'b1;
        tick();
        load_signal = 1'b0;
        check("load_busy", {31'd0, busy}, 32'd1);
        check("load_cnt0", {22'd0, bytes_loaded}, 32'd0);
        received = 1'b1;
        for (int k = 0; k < n; k++) begin
            receive_byte = base + 8'(k);
            model[k]     = base + 8'(k);
            tick();
            check("load_cnt", {22'd0, bytes_loaded}, 32'(k + 1));
            check("load_loaded", {31'd0, loaded}, {31'd0, (k == 24)});
        end
        received = 1'b0;
    endtask

    // One complete playback; strobes are sent throughout and must be ignored.
    task automatic play_capture(output logic [199:0] seq);
        seq = '0;
        play_signal = 1'b1;
        tick();                                   // edge E
        play_signal = 1'b0;
        check("play_busy_E", {31'd0, busy}, 32'd1);
        check("play_valid_E", {31'd0, input_valid}, 32'd0);
`ifdef INPUT_PLAYER_LOOP_EN
        play_signal = 1'b1;                       // stop after first pass
`endif
        received = 1'b1;
        tick();                                   // E+1
        play_signal = 1'b0;
        check("play_valid_E1", {31'd0, input_valid}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            tick();                               // E+2+i
            check("play_valid", {31'd0, input_valid}, 32'd1);
            check("play_bit", {31'd0, input_bit}, {31'd0, exp_bit(i)});
            check("play_busy", {31'd0, busy}, {31'd0, (i < 198)});
            seq[i] = input_bit;
        end
        received = 1'b0;
        tick();
        check("play_tail_valid", {31'd0, input_valid}, 32'd0);
        check("play_bytes_kept", {22'd0, bytes_loaded}, 32'd25);
        check("play_loaded_kept", {31'd0, loaded}, 32'd1);
    endtask

    initial begin
        int n_valid, n_ones, n_runs, first_t, cnt;
        logic prev_v;

        reset = 1'b1;
        received = 1'b0; load_signal = 1'b0; play_signal = 1'b0; receive_byte = '0;
        s_received = 1'b0; s_load = 1'b0; s_play = 1'b0; s_byte = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // ---- 13-sample instance: 0xFF, 0x1F -> 13 ones, bits 13..15 unplayed
        s_load = 1'b1;
        tick();
        s_load = 1'b0;
        check("s13_busy", {31'd0, s_busy}, 32'd1);
        s_received = 1'b1;
        s_byte = 8'hFF;
        tick();
        s_byte = 8'h1F;
        tick();
        s_received = 1'b0;
        check("s13_loaded", {31'd0, s_loaded}, 32'd1);
        check("s13_bytes", {22'd0, s_bytes_loaded}, 32'd2);
        check("s13_idle_busy", {31'd0, s_busy}, 32'd0);
        s_play = 1'b1;
        tick();                                   // edge E
        s_play = 1'b0;
        n_valid = 0; n_ones = 0; n_runs = 0; first_t = -1; prev_v = 1'b0;
        for (int t = 1; t <= 30; t++) begin
`ifdef INPUT_PLAYER_LOOP_EN
            s_play = (t == 1);
`endif
            tick();                               // E+t
            if (s_valid) begin
                n_valid++;
                if (s_bit) n_ones++;
                if (!prev_v) n_runs++;
                if (first_t < 0) first_t = t;
            end
            prev_v = s_valid;
        end
        s_play = 1'b0;
        check("s13_valid_count", 32'(n_valid), 32'd13);
        check("s13_ones_count", 32'(n_ones), 32'd13);
        check("s13_runs", 32'(n_runs), 32'd1);
        check("s13_first_edge", 32'(first_t), 32'd2);

        // ---- play_signal ignored in IDLE
        play_signal = 1'b1;
        tick();
        play_signal = 1'b0;
        tick();
        tick();
        check("idle_play_busy", {31'd0, busy}, 32'd0);
        check("idle_play_valid", {31'd0, input_valid}, 32'd0);

        // ---- full load, ignored strobe in READY, two identical replays
        load_bytes(25, 8'hA5);
        check("ready_busy", {31'd0, busy}, 32'd0);
        received = 1'b1;
        receive_byte = 8'h00;
        tick();
        received = 1'b0;
        check("ready_strobe_bytes", {22'd0, bytes_loaded}, 32'd25);
        play_capture(seq1);
        play_capture(seq2);
        check("replay_lo", seq2[31:0], seq1[31:0]);
        check("replay_hi", seq2[199:168], seq1[199:168]);

        // ---- load and play together in READY: load wins
        load_signal = 1'b1;
        play_signal = 1'b1;
        tick();
        load_signal = 1'b0;
        play_signal = 1'b0;
        check("both_busy", {31'd0, busy}, 32'd1);
        check("both_loaded", {31'd0, loaded}, 32'd0);
        check("both_bytes", {22'd0, bytes_loaded}, 32'd0);
        for (int t = 0; t < 4; t++) begin
            tick();
            check("both_no_valid", {31'd0, input_valid}, 32'd0);
        end

        // ---- reset mid-load after 10 bytes
        load_bytes(10, 8'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midload_reset");
        play_signal = 1'b1;
        tick();
        play_signal = 1'b0;
        tick();
        tick();
        check("midload_play_valid", {31'd0, input_valid}, 32'd0);
        check("midload_play_busy", {31'd0, busy}, 32'd0);

        // ---- reset mid-play at bit 50
        load_bytes(25, 8'h3C);
        play_signal = 1'b1;
        tick();
        play_signal = 1'b0;
`ifdef INPUT_PLAYER_LOOP_EN
        play_signal = 1'b1;
`endif
        tick();
        play_signal = 1'b0;
        for (int i = 0; i <= 50; i++) begin
            tick();
            check("midplay_bit", {31'd0, input_bit}, {31'd0, exp_bit(i)});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midplay_reset");
        play_signal = 1'b1;
        tick();
        play_signal = 1'b0;
        tick();
        tick();
        check("midplay_after_valid", {31'd0, input_valid}, 32'd0);
        check("midplay_after_busy", {31'd0, busy}, 32'd0);

`ifdef INPUT_PLAYER_LOOP_EN
        // ---- continuous playback, stop request at bit 120 of pass 2
        load_bytes(25, 8'h11);
        play_signal = 1'b1;
        tick();
        play_signal = 1'b0;
        cnt = 0;
        for (int t = 0; t < 600; t++) begin
            tick();
            play_signal = 1'b0;
            if (input_valid) begin
                check("loop_bit", {31'd0, input_bit}, {31'd0, exp_bit(cnt % 200)});
                cnt++;
                if (cnt == 321) play_signal = 1'b1;
            end else if (cnt > 0) begin
                break;
            end
        end
        play_signal = 1'b0;
        check("loop_total_valid", 32'(cnt), 32'd400);
        check("loop_end_busy", {31'd0, busy}, 32'd0);
        check("loop_end_loaded", {31'd0, loaded}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_player.md
# input_player

Host-to-reservoir stimulus path: receives an input time series from the host over the USB byte stream, stores it bit-packed, and replays it one bit per clock into the reservoir input. It is the return-direction counterpart of the acquisition path: acquisition captures reservoir dynamics and streams them to the host; this block streams host data into the reservoir. It sits between the USB communications controller (byte/strobe source) and the reservoir controller (bit/valid sink), and is sequenced by the master control FSM.

## Interface
- nr_samples, 200, number of input bits per time series; must match the host-side setting; 1 ≤ nr_samples ≤ 2^log_nr_lines.
- log_nr_lines, 10, width of bit-index and byte-count signals.
- CLOCK_50  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- received  in  1  one-cycle strobe, receive_byte valid.
- receive_byte  in  8  host byte; 8 input bits, LSB = earliest sample.
- load_signal  in  1  level, sampled each edge; start/restart loading.
- play_signal  in  1  level, sampled each edge; start playback.
- input_bit  out  1  current stimulus bit to reservoir.
- input_valid  out  1  input_bit carries sample.
- loaded  out  1  complete series stored and replayable.
- busy  out  1  high in LOAD or PLAY.
- bytes_loaded  out  log_nr_lines  bytes written in current load.

## Operation
- NBYTES = ceil(nr_samples/8); byte k holds samples 8k..8k+7; unused high bits of last byte are stored but never played.
- States: IDLE, LOAD, READY, PLAY.
- IDLE: load_signal → LOAD, bytes_loaded←0, loaded←0. play_signal ignored.
- LOAD: each received strobe writes receive_byte to address bytes_loaded, bytes_loaded++. On write of byte NBYTES-1 → READY, loaded←1. load_signal in LOAD restarts (count←0, same-edge byte discarded).
- READY: load_signal → LOAD (loaded←0). Else play_signal → PLAY, idx←0. Both high: load wins.
- PLAY: idx increments each clock 0..nr_samples-1; after idx nr_samples-1 → READY. load_signal and play_signal ignored (except loop mode, below). Data retained; replay unlimited.
- received outside LOAD ignored; no write.
- Reset from any state, including mid-load or mid-play: → IDLE, next edge outputs all 0; memory contents need not be cleared but are unplayable until reloaded.
- Reset values: input_bit 0, input_valid 0, loaded 0, busy 0, bytes_loaded 0.

## Timing
- Write: strobe sampled at edge E → bytes_loaded updated at E; loaded/READY visible after E for final byte.
- Playback latency: play_signal sampled at edge E → input_valid high after edges E+2 through E+nr_samples+1; bit i appears after edge E+2+i; input_valid exactly nr_samples consecutive cycles, no gaps.
- busy high from edge E (entry to PLAY) until PLAY exits; trailing pipeline output follows for 2 cycles after busy falls.
- Back-to-back strobes (every cycle) accepted without loss.

## Configuration
- INPUT_PLAYER_LOOP_EN defined: PLAY wraps idx from nr_samples-1 to 0 continuously; play_signal high during PLAY latches a stop request; playback ends after bit nr_samples-1 of current pass, then READY. load_signal during PLAY also stops at pass end, then → LOAD.
- Undefined: single pass per play_signal, as above; no stop-request logic.

## Structure
- Package input_player_pkg: state enum (IDLE, LOAD, READY, PLAY), NBYTES constant function of nr_samples.
- Sub-module input_player_mem: NBYTES×8 byte RAM, one synchronous write port, one registered read port (1-cycle read latency); bit select and output register in top level give the 2-cycle playback latency.

## Test plan
- nr_samples=200: load_signal, 25 bytes 0xA5.. incrementing → loaded=1 after byte 25, bytes_loaded=25; play → 200 valid cycles, bit i = byte[i/8][i%8], first valid 2 edges after play.
- nr_samples=13: 2 bytes 0xFF,0x1F → exactly 13 valid bits all 1; bits 13–15 never output.
- Reset asserted mid-load after 10 bytes and mid-play at bit 50 → all outputs 0 next cycle, state IDLE, play_signal then ignored.
- load_signal and play_signal high together in READY → LOAD entered, loaded=0, no input_valid; received strobes while READY/PLAY → bytes_loaded unchanged.
- Replay: play twice after one load → identical 200-bit sequences.
- INPUT_PLAYER_LOOP_EN: play, stop request at bit 120 of pass 2 → output continues to bit 199 of pass 2 then input_valid drops; total 400 valid cycles.
